irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter INT_BASE, 32'h0000_0080, vector address of source 1.
REQ-002 Parameter VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive source vectors.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  in  1  synchronous, active-low reset; asserted when low, sampled only on rising clk.
REQ-005 done1..done4  in  1 each  peripheral completion lines; done1 highest priority, done4 lowest.
REQ-006 int_ack  in  1  CPU acceptance pulse; PC loads int_addr in the same cycle.
REQ-007 int_done  in  1  CPU return-from-interrupt pulse (JEPC executed).
REQ-008 interrupt  out  1  request to the CPU interrupt encoder.
REQ-009 int_addr  out  32  handler vector for the selected source.
REQ-010 active_id  out  2  selected source index, 0 = done1 .. 3 = done4.
REQ-011 pending  out  4  latched-request bits, bit0 = done1.

Function
REQ-012 Each doneN SHALL be registered; a rising edge (current 1, previous 0) SHALL set pending[N-1] on that clock edge.
REQ-013 An edge on a source whose pending bit is already set SHALL coalesce; no count is kept.
REQ-014 Simultaneous edges on several sources SHALL set all the corresponding bits in the same cycle.
REQ-015 FSM states: IDLE, ASSERT, SERVICE.
REQ-016 IDLE with enabled pending != 0: latch the highest-priority enabled pending index into active_id and go to ASSERT next edge.
REQ-017 ASSERT: interrupt = 1; on int_ack, clear pending[active_id] and go to SERVICE.
REQ-018 SERVICE: interrupt = 0; on int_done go to IDLE, otherwise hold.
REQ-019 interrupt SHALL be registered, equal to (state == ASSERT); minimum latency from a doneN rise to interrupt high is 2 cycles.
REQ-020 int_addr SHALL equal INT_BASE + active_id * VEC_STRIDE (32-bit, wrap on overflow).
REQ-021 int_addr and active_id SHALL stay stable from entry to ASSERT until the return to IDLE.
REQ-022 A new edge on a source in the same cycle its pending bit is cleared by int_ack SHALL leave the bit set (set wins).
REQ-023 Edges arriving in ASSERT or SERVICE SHALL be latched and served only after the return to IDLE; there is no nesting or preemption.
REQ-024 int_ack outside ASSERT SHALL be ignored.
REQ-025 int_done outside SERVICE SHALL be ignored.
REQ-026 A higher-priority edge during ASSERT SHALL NOT change active_id.

Reset
REQ-027 When reset is low at a clock edge, the next state SHALL be: state IDLE, interrupt 0, active_id 0, pending 4'b0000, done-history registers 0, int_addr INT_BASE.
REQ-028 Reset mid-ASSERT or mid-SERVICE SHALL abandon the transaction and drop all pending requests.
REQ-029 A done line held high through reset release SHALL register as an edge on the first cycle after release.

Configuration
REQ-030 Macro IRQ_MASK_EN defined: add ports mask_we (in, 1), mask_d (in, 4) and mask (out, 4, reset 4'b1111).
REQ-031 With IRQ_MASK_EN: mask_we loads mask_d; a masked source still sets its pending bit but is excluded from selection; unmasking makes the request eligible.
REQ-032 IRQ_MASK_EN undefined: no mask ports exist and all sources are always enabled.

Structure
REQ-033 Shared package irq_pkg SHALL hold: NUM_SRC = 4, the ID width (2), the FSM state encoding (IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2) and the default INT_BASE / VEC_STRIDE constants.
REQ-034 One sub-module irq_prienc SHALL provide the combinational 4-to-2 fixed-priority encoder with a valid flag, instantiated once.

Verification
REQ-035 done3 rises at cycle 0 -> pending = 4'b0100 after edge 0; interrupt = 1 after edge 1 with int_addr = 32'h0000_00A0 and active_id = 2.
REQ-036 done2 and done4 rise together, then int_ack -> first vector 32'h0000_0090; after int_done, second vector 32'h0000_00B0; pending returns to 0.
REQ-037 done1 rises during SERVICE of source 4 -> interrupt stays 0 until int_done; then the next vector is 32'h0000_0080.
REQ-038 done2 re-rises in the same cycle int_ack clears source 2 -> pending[1] remains 1 and the source is re-served after int_done.
REQ-039 reset driven low during ASSERT with pending = 4'b1010 -> after the edge, interrupt = 0, pending = 0 and state IDLE; stray int_ack and int_done pulses have no effect.
REQ-040 With IRQ_MASK_EN, mask = 4'b1110 and done1 rises -> pending[0] = 1 and interrupt stays 0; writing mask = 4'b1111 -> interrupt asserts 2 cycles later with vector 32'h0000_0080.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count, ID width,
// FSM encoding, default vector layout and the vector address helper.
package irq_pkg;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ID_W    = 2;

   localparam logic [31:0] INT_BASE_DEF   = 32'h0000_0080;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   // Handler address for a source index; wraps modulo 2^32.
   function automatic logic [31:0] vec_addr(input logic [31:0]     base,
                                            input logic [31:0]     stride,
                                            input logic [ID_W-1:0] id);
      return base + (32'(id) * stride);
   endfunction

endpackage : irq_pkg

// File: rtl/irq_controller_if.sv
// Peripheral/CPU side signals of the interrupt controller.
// slave: controller view; master: CPU/peripheral (stimulus) view.
interface irq_controller_if;
   import irq_pkg::*;

   logic              done1;
   logic              done2;
   logic              done3;
   logic              done4;
   logic              int_ack;
   logic              int_done;
   logic              interrupt;
   logic [31:0]       int_addr;
   logic [ID_W-1:0]   active_id;
   logic [NUM_SRC-1:0] pending;

   modport slave (
      input  done1, done2, done3, done4, int_ack, int_done,
      output interrupt, int_addr, active_id, pending
   );

   modport master (
      output done1, done2, done3, done4, int_ack, int_done,
      input  interrupt, int_addr, active_id, pending
   );

endinterface : irq_controller_if

// File: rtl/irq_controller_prienc.sv
// Combinational fixed-priority encoder: lowest set index wins (done1 first).
module irq_prienc
   import irq_pkg::*;
(
   input  logic [NUM_SRC-1:0] req_i,
   output logic [ID_W-1:0]    idx_c,
   output logic               valid_c
);

   // Scan from lowest priority upward so the highest-priority hit is last written.
   always_comb begin
      idx_c   = '0;
      valid_c = 1'b0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_c   = ID_W'(i);
            valid_c = 1'b1;
         end
      end
   end

endmodule : irq_prienc

// File: rtl/irq_controller.sv
// Four-source edge-latched interrupt controller with a single outstanding
// request to the CPU (IDLE -> ASSERT -> SERVICE, no nesting).
// Optional feature: define IRQ_MASK_EN to add a writable per-source mask.
module irq_controller
   import irq_pkg::*;
#(
   parameter logic [31:0] INT_BASE   = INT_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               reset,
`ifdef IRQ_MASK_EN
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_d,
   output logic [NUM_SRC-1:0] mask,
`endif
   irq_controller_if.slave    bus
);

   irq_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] done_q, done_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [ID_W-1:0]    active_id_q, active_id_d;
   logic [31:0]        int_addr_q, int_addr_d;
   logic               interrupt_q, interrupt_d;

   logic [NUM_SRC-1:0] rise_c;
   logic [NUM_SRC-1:0] clr_c;
   logic [NUM_SRC-1:0] enable_c;
   logic [ID_W-1:0]    sel_idx_c;
   logic               sel_valid_c;

   assign done_d = {bus.done4, bus.done3, bus.done2, bus.done1};
   assign rise_c = done_d & ~done_q;

`ifdef IRQ_MASK_EN
   logic [NUM_SRC-1:0] mask_q;

   // Mask register; a masked source still latches but is not selectable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q <= '1;
      end else if (mask_we) begin
         mask_q <= mask_d;
      end
   end

   assign mask     = mask_q;
   assign enable_c = mask_q;
`else
   assign enable_c = '1;
`endif

   irq_prienc u_prienc (
      .req_i   (pending_q & enable_c),
      .idx_c   (sel_idx_c),
      .valid_c (sel_valid_c)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         done_q      <= '0;
         pending_q   <= '0;
         active_id_q <= '0;
         int_addr_q  <= INT_BASE;
         interrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         pending_q   <= pending_d;
         active_id_q <= active_id_d;
         int_addr_q  <= int_addr_d;
         interrupt_q <= interrupt_d;
      end
   end

   // Next-state: select in IDLE, hold selection until return; new edges win over ack clear.
   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      int_addr_d  = int_addr_q;
      clr_c       = '0;

      case (state_q)
         IDLE: begin
            if (sel_valid_c) begin
               active_id_d = sel_idx_c;
               int_addr_d  = vec_addr(INT_BASE, VEC_STRIDE, sel_idx_c);
               state_d     = ASSERT;
            end
         end
         ASSERT: begin
            if (bus.int_ack) begin
               clr_c   = NUM_SRC'(1) << active_id_q;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.int_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      pending_d   = (pending_q & ~clr_c) | rise_c;
      interrupt_d = (state_d == ASSERT);
   end

   assign bus.interrupt = interrupt_q;
   assign bus.int_addr  = int_addr_q;
   assign bus.active_id = active_id_q;
   assign bus.pending   = pending_q;

endmodule : irq_controller
